// File: rtl/ccc_pkg.sv
// ccc_pkg
// Shared definitions for the broadcast-CCC sequencer:
//   - ccc_state_e : sequencer state encoding (3 bits, 3'b111 unused)
//   - TX_SERIAL / TX_PARITY : TX block mode codes
//   - RX_ARB / RX_ACK       : RX block mode codes
//   - ctr_width()           : retry counter width, never below 1 bit
package ccc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BCAST   = 3'd1,
    ST_ACK     = 3'd2,
    ST_CCC     = 3'd3,
    ST_PAR     = 3'd4,
    ST_DEF     = 3'd5,
    ST_DEF_PAR = 3'd6
  } ccc_state_e;

  localparam logic [2:0] TX_SERIAL = 3'b001;
  localparam logic [2:0] TX_PARITY = 3'b011;
  localparam logic [2:0] RX_ARB    = 3'b010;
  localparam logic [2:0] RX_ACK    = 3'b000;

  // $clog2(1) is 0, so MAX_RETRY=0 would otherwise give a zero-width counter.
  function automatic int ctr_width(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/ccc_retry_ctr.sv
// ccc_retry_ctr
// Saturating retry counter for the broadcast NACK retry loop.
// Ports:
//   clk       in   system clock
//   srst      in   synchronous active-high reset (count -> 0)
//   clr       in   clear count to 0 (wins over inc)
//   inc       in   increment, holds at MAX_RETRY
//   exhausted out  count == MAX_RETRY (no retries left)
module ccc_retry_ctr
  import ccc_pkg::*;
#(
  parameter int MAX_RETRY = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic inc,
  output logic exhausted
);

  localparam int CW = ctr_width(MAX_RETRY);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_RETRY);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign exhausted = (count_reg == CNT_MAX);

endmodule

// File: rtl/ccc_bcast_seq.sv
// ccc_bcast_seq
// Broadcast-CCC sequencer: drives TX/RX through broadcast address, ACK slot,
// CCC code + T-bit and (optionally) defining byte + T-bit, with a bounded
// re-broadcast on NACK. All outputs are registered.
//
// Optional feature macro: CCC_DEF_BYTE_EN
//   defined   -> i_def_sel / i_def_vld ports, DEF_BASE_ADDR parameter and
//                DEF / DEF_PAR states exist
//   undefined -> PAR always completes with o_done
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_engine_en             start request (only looked at in IDLE)
//   i_ccc_sel               CCC index, captured at start
//   i_def_sel, i_def_vld    defining-byte index / request (macro only)
//   i_tx_mode_done          TX finished current mode (pulse)
//   i_rx_ack_nack           ACK slot result, 1 = NACK
//   o_regf_rd_en/o_regf_addr  register-file read strobe and address
//   o_tx_en/o_tx_mode       TX command strobe and mode
//   o_rx_en/o_rx_mode       RX command strobe and mode
//   o_busy                  high outside IDLE
//   o_done, o_nack_err      completion / NACK-exhausted pulses
module ccc_bcast_seq
  import ccc_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int BCAST_ADDR    = 46,
  parameter int CCC_BASE_ADDR = 48,
`ifdef CCC_DEF_BYTE_EN
  parameter int DEF_BASE_ADDR = 64,
`endif
  parameter int SEL_W         = 3,
  parameter int MAX_RETRY     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_engine_en,
  input  logic [SEL_W-1:0]  i_ccc_sel,
`ifdef CCC_DEF_BYTE_EN
  input  logic [SEL_W-1:0]  i_def_sel,
  input  logic              i_def_vld,
`endif
  input  logic              i_tx_mode_done,
  input  logic              i_rx_ack_nack,
  output logic              o_regf_rd_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic              o_tx_en,
  output logic [2:0]        o_tx_mode,
  output logic              o_rx_en,
  output logic [2:0]        o_rx_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_nack_err
);

  ccc_state_e state_reg, state_next;

  logic [SEL_W-1:0] ccc_sel_reg, ccc_sel_next;
`ifdef CCC_DEF_BYTE_EN
  logic [SEL_W-1:0] def_sel_reg, def_sel_next;
  logic             def_vld_reg, def_vld_next;
`endif

  logic              regf_rd_en_reg, regf_rd_en_next;
  logic [ADDR_W-1:0] regf_addr_reg, regf_addr_next;
  logic              tx_en_reg, tx_en_next;
  logic [2:0]        tx_mode_reg, tx_mode_next;
  logic              rx_en_reg, rx_en_next;
  logic [2:0]        rx_mode_reg, rx_mode_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              nack_err_reg, nack_err_next;

  logic retry_clr;
  logic retry_inc;
  logic retry_exhausted;
  logic bcast_cmd;

  ccc_retry_ctr #(
    .MAX_RETRY (MAX_RETRY)
  ) u_retry_ctr (
    .clk       (i_clk),
    .srst      (i_rst),
    .clr       (retry_clr),
    .inc       (retry_inc),
    .exhausted (retry_exhausted)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      ccc_sel_reg    <= '0;
`ifdef CCC_DEF_BYTE_EN
      def_sel_reg    <= '0;
      def_vld_reg    <= 1'b0;
`endif
      regf_rd_en_reg <= 1'b0;
      regf_addr_reg  <= '0;
      tx_en_reg      <= 1'b0;
      tx_mode_reg    <= '0;
      rx_en_reg      <= 1'b0;
      rx_mode_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      nack_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ccc_sel_reg    <= ccc_sel_next;
`ifdef CCC_DEF_BYTE_EN
      def_sel_reg    <= def_sel_next;
      def_vld_reg    <= def_vld_next;
`endif
      regf_rd_en_reg <= regf_rd_en_next;
      regf_addr_reg  <= regf_addr_next;
      tx_en_reg      <= tx_en_next;
      tx_mode_reg    <= tx_mode_next;
      rx_en_reg      <= rx_en_next;
      rx_mode_reg    <= rx_mode_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      nack_err_reg   <= nack_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ccc_sel_next    = ccc_sel_reg;
`ifdef CCC_DEF_BYTE_EN
    def_sel_next    = def_sel_reg;
    def_vld_next    = def_vld_reg;
`endif
    regf_rd_en_next = 1'b0;
    regf_addr_next  = '0;
    tx_en_next      = 1'b0;
    tx_mode_next    = '0;
    rx_en_next      = 1'b0;
    rx_mode_next    = '0;
    done_next       = 1'b0;
    nack_err_next   = 1'b0;
    retry_clr       = 1'b0;
    retry_inc       = 1'b0;
    bcast_cmd       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_engine_en) begin
          ccc_sel_next = i_ccc_sel;
`ifdef CCC_DEF_BYTE_EN
          def_sel_next = i_def_sel;
          def_vld_next = i_def_vld;
`endif
          retry_clr    = 1'b1;
          bcast_cmd    = 1'b1;
          state_next   = ST_BCAST;
        end
      end

      ST_BCAST: begin
        if (i_tx_mode_done) begin
          rx_en_next   = 1'b1;
          rx_mode_next = RX_ACK;
          state_next   = ST_ACK;
        end
      end

      // The ACK slot result is taken on the single cycle spent here.
      ST_ACK: begin
        if (!i_rx_ack_nack) begin
          regf_rd_en_next = 1'b1;
          regf_addr_next  = ADDR_W'(CCC_BASE_ADDR) + ADDR_W'(ccc_sel_reg);
          tx_en_next      = 1'b1;
          tx_mode_next    = TX_SERIAL;
          state_next      = ST_CCC;
        end else if (!retry_exhausted) begin
          retry_inc  = 1'b1;
          bcast_cmd  = 1'b1;
          state_next = ST_BCAST;
        end else begin
          nack_err_next = 1'b1;
          state_next    = ST_IDLE;
        end
      end

      ST_CCC: begin
        if (i_tx_mode_done) begin
          tx_en_next   = 1'b1;
          tx_mode_next = TX_PARITY;
          state_next   = ST_PAR;
        end
      end

      ST_PAR: begin
        if (i_tx_mode_done) begin
`ifdef CCC_DEF_BYTE_EN
          if (def_vld_reg) begin
            regf_rd_en_next = 1'b1;
            regf_addr_next  = ADDR_W'(DEF_BASE_ADDR) + ADDR_W'(def_sel_reg);
            tx_en_next      = 1'b1;
            tx_mode_next    = TX_SERIAL;
            state_next      = ST_DEF;
          end else begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
`else
          done_next  = 1'b1;
          state_next = ST_IDLE;
`endif
        end
      end

`ifdef CCC_DEF_BYTE_EN
      ST_DEF: begin
        if (i_tx_mode_done) begin
          tx_en_next   = 1'b1;
          tx_mode_next = TX_PARITY;
          state_next   = ST_DEF_PAR;
        end
      end

      ST_DEF_PAR: begin
        if (i_tx_mode_done) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif

      // Unused encodings (and DEF states when the feature is compiled out)
      // fall back to IDLE with every command left at its 0 default.
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Broadcast entry is issued both from IDLE and from a NACK retry.
    if (bcast_cmd) begin
      rx_en_next      = 1'b1;
      rx_mode_next    = RX_ARB;
      regf_rd_en_next = 1'b1;
      regf_addr_next  = ADDR_W'(BCAST_ADDR);
      tx_en_next      = 1'b1;
      tx_mode_next    = TX_SERIAL;
    end

    busy_next = (state_next != ST_IDLE);
  end

  assign o_regf_rd_en = regf_rd_en_reg;
  assign o_regf_addr  = regf_addr_reg;
  assign o_tx_en      = tx_en_reg;
  assign o_tx_mode    = tx_mode_reg;
  assign o_rx_en      = rx_en_reg;
  assign o_rx_mode    = rx_mode_reg;
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;
  assign o_nack_err   = nack_err_reg;

endmodule

// File: tb/tb_ccc_bcast_seq.sv
// tb_ccc_bcast_seq
// Directed bench for ccc_bcast_seq with default parameters. The defining-byte
// scenario is built only when CCC_DEF_BYTE_EN is defined.
module tb_ccc_bcast_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       engine_en;
  logic [2:0] ccc_sel;
`ifdef CCC_DEF_BYTE_EN
  logic [2:0] def_sel;
  logic       def_vld;
`endif
  logic       tx_mode_done;
  logic       rx_ack_nack;
  logic       regf_rd_en;
  logic [9:0] regf_addr;
  logic       tx_en;
  logic [2:0] tx_mode;
  logic       rx_en;
  logic [2:0] rx_mode;
  logic       busy;
  logic       done;
  logic       nack_err;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  int rd_q[$];
  int tx_q[$];
  int done_cnt = 0;
  int nack_cnt = 0;

  always #5 clk = ~clk;

  ccc_bcast_seq dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_engine_en    (engine_en),
    .i_ccc_sel      (ccc_sel),
`ifdef CCC_DEF_BYTE_EN
    .i_def_sel      (def_sel),
    .i_def_vld      (def_vld),
`endif
    .i_tx_mode_done (tx_mode_done),
    .i_rx_ack_nack  (rx_ack_nack),
    .o_regf_rd_en   (regf_rd_en),
    .o_regf_addr    (regf_addr),
    .o_tx_en        (tx_en),
    .o_tx_mode      (tx_mode),
    .o_rx_en        (rx_en),
    .o_rx_mode      (rx_mode),
    .o_busy         (busy),
    .o_done         (done),
    .o_nack_err     (nack_err)
  );

  // Event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (regf_rd_en) rd_q.push_back(int'(regf_addr));
    if (tx_en) tx_q.push_back(int'(tx_mode));
    if (done) done_cnt++;
    if (nack_err) nack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_q.delete();
    tx_q.delete();
    done_cnt = 0;
    nack_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(regf_rd_en), 0);
    check({tag, "_addr"}, 32'(regf_addr), 0);
    check({tag, "_tx_en"}, 32'(tx_en), 0);
    check({tag, "_tx_mode"}, 32'(tx_mode), 0);
    check({tag, "_rx_en"}, 32'(rx_en), 0);
    check({tag, "_rx_mode"}, 32'(rx_mode), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_nack"}, 32'(nack_err), 0);
  endtask

  // Start and verify the broadcast entry commands one edge later.
  task automatic do_start(input logic [2:0] sel);
    ccc_sel   = sel;
    engine_en = 1'b1;
    step();
    engine_en = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_rd_en", 32'(regf_rd_en), 1);
    check("start_addr", 32'(regf_addr), 46);
    check("start_tx_mode", 32'(tx_mode), 1);
    check("start_rx_en", 32'(rx_en), 1);
    check("start_rx_mode", 32'(rx_mode), 2);
  endtask

  task automatic tx_pulse();
    tx_mode_done = 1'b1;
    step();
    tx_mode_done = 1'b0;
  endtask

  task automatic ack_slot(input logic nack);
    rx_ack_nack = nack;
    step();
    rx_ack_nack = 1'b0;
  endtask

  // Broadcast phase then ACK slot; checks ACK-slot RX command on the way.
  task automatic bcast_and_slot(input logic nack);
    tx_pulse();
    check("ack_rx_en", 32'(rx_en), 1);
    check("ack_rx_mode", 32'(rx_mode), 0);
    ack_slot(nack);
  endtask

  function automatic int count_addr(input int addr);
    int n = 0;
    foreach (rd_q[i]) if (rd_q[i] == addr) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    engine_en    = 1'b0;
    ccc_sel      = '0;
`ifdef CCC_DEF_BYTE_EN
    def_sel      = '0;
    def_vld      = 1'b0;
`endif
    tx_mode_done = 1'b0;
    rx_ack_nack  = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // 1: ccc_sel=0, ACK, 3 tx_done pulses.
    clear_log();
    do_start(3'd0);
    step();
    check("strobe_one_cycle", 32'(regf_rd_en), 0);
    check("busy_hold", 32'(busy), 1);
    engine_en = 1'b1;              // must be ignored while busy
    step();
    engine_en = 1'b0;
    check("busy_start_ignored", 32'(regf_rd_en), 0);
    bcast_and_slot(1'b0);
    check("ccc_rd_en", 32'(regf_rd_en), 1);
    check("ccc_addr_sel0", 32'(regf_addr), 48);
    tx_pulse();
    check("par_tx_mode", 32'(tx_mode), 3);
    check("par_busy", 32'(busy), 1);
    check("par_done", 32'(done), 0);
    tx_pulse();
    check("done_pulse", 32'(done), 1);
    check("done_busy_low", 32'(busy), 0);
    step();
    check("done_one_cycle", 32'(done), 0);
    check("t1_reads", 32'(rd_q.size()), 2);
    if (rd_q.size() == 2) begin
      check("t1_rd0", 32'(rd_q[0]), 46);
      check("t1_rd1", 32'(rd_q[1]), 48);
    end
    check("t1_tx_count", 32'(tx_q.size()), 3);
    if (tx_q.size() == 3) begin
      check("t1_tx0", 32'(tx_q[0]), 1);
      check("t1_tx1", 32'(tx_q[1]), 1);
      check("t1_tx2", 32'(tx_q[2]), 3);
    end
    check("t1_done_cnt", 32'(done_cnt), 1);
    $display("seq basic: reads=%0d tx_cmds=%0d done=%0d", rd_q.size(), tx_q.size(), done_cnt);

    // tx_done in IDLE is ignored.
    tx_pulse();
    check("idle_txdone_busy", 32'(busy), 0);
    check("idle_txdone_tx_en", 32'(tx_en), 0);

    // 2: ccc_sel=5 -> CCC address 53.
    clear_log();
    do_start(3'd5);
    bcast_and_slot(1'b0);
    check("ccc_addr_sel5", 32'(regf_addr), 53);
    tx_pulse();
    tx_pulse();
    check("sel5_done", 32'(done), 1);
    step();
    $display("seq ccc_sel=5: reads=%0d done=%0d", rd_q.size(), done_cnt);

    // 3: NACK, NACK, ACK.
    clear_log();
    do_start(3'd1);
    bcast_and_slot(1'b1);
    check("retry1_rd_en", 32'(regf_rd_en), 1);
    check("retry1_addr", 32'(regf_addr), 46);
    check("retry1_rx_mode", 32'(rx_mode), 2);
    bcast_and_slot(1'b1);
    check("retry2_addr", 32'(regf_addr), 46);
    check("retry2_busy", 32'(busy), 1);
    bcast_and_slot(1'b0);
    check("retry_ccc_addr", 32'(regf_addr), 49);
    tx_pulse();
    tx_pulse();
    check("retry_done", 32'(done), 1);
    step();
    check("retry_bcast_reads", 32'(count_addr(46)), 3);
    check("retry_done_cnt", 32'(done_cnt), 1);
    check("retry_nack_cnt", 32'(nack_cnt), 0);
    $display("seq nack,nack,ack: bcast_reads=%0d done=%0d", count_addr(46), done_cnt);

    // 4: NACK x3 -> error.
    clear_log();
    do_start(3'd0);
    bcast_and_slot(1'b1);
    bcast_and_slot(1'b1);
    bcast_and_slot(1'b1);
    check("exh_nack_err", 32'(nack_err), 1);
    check("exh_busy", 32'(busy), 0);
    check("exh_done", 32'(done), 0);
    check("exh_rd_en", 32'(regf_rd_en), 0);
    step();
    check("exh_nack_one_cycle", 32'(nack_err), 0);
    check("exh_nack_cnt", 32'(nack_cnt), 1);
    check("exh_done_cnt", 32'(done_cnt), 0);
    check("exh_bcast_reads", 32'(count_addr(46)), 3);
    $display("seq nack x3: nack_err=%0d done=%0d", nack_cnt, done_cnt);

    // 5: reset while in CCC, then a fresh start with full retry budget.
    clear_log();
    do_start(3'd2);
    bcast_and_slot(1'b1);
    bcast_and_slot(1'b0);
    check("pre_rst_ccc_addr", 32'(regf_addr), 50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("mid_rst");
    check("mid_rst_no_done", 32'(done_cnt), 0);
    check("mid_rst_no_nack", 32'(nack_cnt), 0);
    do_start(3'd0);
    bcast_and_slot(1'b1);
    check("post_rst_retry1", 32'(regf_addr), 46);
    bcast_and_slot(1'b1);
    check("post_rst_retry2", 32'(regf_addr), 46);
    check("post_rst_retry2_nack", 32'(nack_err), 0);
    bcast_and_slot(1'b1);
    check("post_rst_exhaust", 32'(nack_err), 1);
    step();
    $display("seq reset in CCC: nack_err=%0d done=%0d", nack_cnt, done_cnt);

`ifdef CCC_DEF_BYTE_EN
    // 6: defining byte 2 -> address 66, done after 5th tx_done.
    clear_log();
    def_sel = 3'd2;
    def_vld = 1'b1;
    do_start(3'd0);
    def_vld = 1'b0;
    def_sel = 3'd0;
    bcast_and_slot(1'b0);
    tx_pulse();
    tx_pulse();
    check("def_rd_en", 32'(regf_rd_en), 1);
    check("def_addr", 32'(regf_addr), 66);
    check("def_no_done", 32'(done), 0);
    tx_pulse();
    check("def_par_tx_mode", 32'(tx_mode), 3);
    check("def_par_no_done", 32'(done), 0);
    tx_pulse();
    check("def_done", 32'(done), 1);
    check("def_busy_low", 32'(busy), 0);
    step();
    check("def_done_cnt", 32'(done_cnt), 1);
    $display("seq def byte: reads=%0d done=%0d", rd_q.size(), done_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ccc_bcast_seq.md
# ccc_bcast_seq

Parametrised broadcast-CCC sequencer in the I3C engine. It generalises the fixed ENTHDR0 flow to any broadcast CCC stored in the register file, with a bounded NACK retry and an optional defining byte. When started, it drives the TX and RX blocks through these phases: arbitration/broadcast address, ACK, CCC code + T-bit, and optionally defining byte + T-bit. It reports completion or NACK failure to the engine controller.

## Interface
- ADDR_W, 10, register-file address width
- BCAST_ADDR, 46, regfile address of broadcast header 7E+W
- CCC_BASE_ADDR, 48, regfile address of CCC code 0; CCC n sits at CCC_BASE_ADDR+n
- DEF_BASE_ADDR, 64, regfile address of defining byte 0
- SEL_W, 3, width of CCC/defining-byte selectors
- MAX_RETRY, 2, broadcast re-attempts after NACK (0 = no retry)
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_engine_en  in  1  start request, sampled only in IDLE
- i_ccc_sel  in  SEL_W  CCC index, captured at start
- i_def_sel  in  SEL_W  defining-byte index, captured at start (CCC_DEF_BYTE_EN only)
- i_def_vld  in  1  defining byte required, captured at start (CCC_DEF_BYTE_EN only)
- i_tx_mode_done  in  1  TX finished current mode (one-cycle pulse)
- i_rx_ack_nack  in  1  ACK slot result, 0 = ACK, 1 = NACK; valid while in ACK
- o_regf_rd_en  out  1  regfile read strobe
- o_regf_addr  out  ADDR_W  regfile read address
- o_tx_en  out  1  TX command strobe
- o_tx_mode  out  3  TX mode: 001 serialize, 011 parity/T-bit
- o_rx_en  out  1  RX command strobe
- o_rx_mode  out  3  RX mode: 010 arbitration, 000 ACK
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse: sequence completed with ACK
- o_nack_err  out  1  one-cycle pulse: NACK after retries exhausted

## Operation
- All outputs are registered. Every output resets to 0, the state resets to IDLE, and retry_cnt resets to 0.
- Command outputs (regf_rd_en, regf_addr, tx_en, tx_mode, rx_en, rx_mode) default to 0 every cycle. They are asserted for exactly one cycle, on the transition into a phase. TX and RX latch them.
- States: IDLE, BCAST, ACK, CCC, PAR, DEF, DEF_PAR.
- IDLE: when i_engine_en=1, capture the selectors and clear retry_cnt. Go to BCAST and issue rx_en/rx_mode=010, regf_rd_en, addr=BCAST_ADDR, tx_en/tx_mode=001.
- BCAST: on i_tx_mode_done, go to ACK and issue rx_en/rx_mode=000.
- ACK: i_rx_ack_nack is sampled on the first cycle in ACK.
  - If ACK: go to CCC and issue regf_rd_en, addr=CCC_BASE_ADDR+ccc_sel (ADDR_W-bit add, wrap permitted), tx_en/tx_mode=001.
  - If NACK and retry_cnt<MAX_RETRY: increment retry_cnt, go to BCAST, and reissue the BCAST entry commands.
  - If NACK and retries are exhausted: pulse o_nack_err and go to IDLE.
- CCC: on i_tx_mode_done, go to PAR and issue tx_en/tx_mode=011.
- PAR: on i_tx_mode_done:
  - If defining byte is enabled and captured: go to DEF and issue regf_rd_en, addr=DEF_BASE_ADDR+def_sel, tx_en/tx_mode=001.
  - Otherwise: pulse o_done and go to IDLE.
- DEF: on i_tx_mode_done, go to DEF_PAR and issue tx_en/tx_mode=011.
- DEF_PAR: on i_tx_mode_done, pulse o_done and go to IDLE.
- i_engine_en is ignored while busy.
- i_tx_mode_done is ignored in IDLE and ACK.
- Illegal state encodings: go to IDLE with all outputs 0.

## Timing
- Start: i_engine_en is high at edge N. BCAST commands and o_busy are valid after edge N.
- Each phase transition takes one cycle after the qualifying input edge. No combinational paths from inputs to outputs.
- o_done / o_nack_err are asserted in the same cycle as o_busy falls. A new start is accepted on the next edge.
- Minimum sequence without defining byte: start + 3 tx_done pulses + ACK cycle. o_done follows the last tx_done by 1 cycle.
- Reset mid-sequence: at the next edge, all outputs are 0, the state is IDLE, and captured selectors and retry_cnt are cleared. No done or error pulse is generated.
- i_rst has priority over all inputs.

## Configuration
- CCC_DEF_BYTE_EN
  - Defined: i_def_sel and i_def_vld exist, and the DEF/DEF_PAR states are implemented.
  - Undefined: those ports are absent, the states are not compiled, and PAR always completes to IDLE with o_done.

## Structure
- Shared package ccc_pkg holds:
  - the state enum;
  - TX mode constants TX_SERIAL=3'b001 and TX_PARITY=3'b011;
  - RX mode constants RX_ARB=3'b010 and RX_ACK=3'b000.
- One sub-module, ccc_retry_ctr: a saturating counter of width $clog2(MAX_RETRY+1) with clear and increment. It outputs `exhausted` when count==MAX_RETRY.

## Test plan
- Defaults, i_ccc_sel=0, ACK, 3 tx_done pulses:
  - Addresses are 46 then 48.
  - tx_mode sequence is 001,001,011.
  - o_done pulses once; o_busy is high from the cycle after start until the o_done cycle.
- i_ccc_sel=5: CCC read address is 53.
- With CCC_DEF_BYTE_EN, i_def_vld=1, i_def_sel=2: a read of address 66 follows the first T-bit, and o_done comes only after the 5th tx_done.
- NACK, NACK, ACK with MAX_RETRY=2:
  - BCAST is reissued twice.
  - Address 46 is read 3 times, and the sequence then completes with o_done.
- NACK ×3 with MAX_RETRY=2: o_nack_err pulses once, o_done stays 0, and the block is back in IDLE.
- i_rst=1 while in CCC: all outputs are 0 next cycle, and a fresh start reissues BCAST with retry_cnt=0.
